// File: rtl/wb_unit_pkg.sv
// Shared widths, load funct3 encodings and the writeback source select.
package wb_unit_pkg;

  localparam int WB_DATA_WIDTH  = 32;
  localparam int WB_REG_NUM     = 32;
  localparam int WB_REG_NUM_BIT = 5;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_ALU  = 2'd1,
    SRC_LSU  = 2'd2
  } wb_src_e;

endpackage

// File: rtl/wb_unit_load_align.sv
// Combinational load lane select and sign/zero extension with misalignment detect.
// Unknown funct3 encodings behave as a word load.
module wb_unit_load_align
  import wb_unit_pkg::*;
#(
  parameter int DATA_WIDTH = WB_DATA_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] rdata_i,
  input  logic [2:0]            funct3_i,
  input  logic [1:0]            addr_lo_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  misalign_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rdata_i[{addr_lo_i, 3'b000} +: 8];
  assign half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

  always_comb begin
    data_o     = rdata_i;
    misalign_o = 1'b0;
    case (funct3_i)
      F3_LB:  data_o = {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
      F3_LBU: data_o = {{(DATA_WIDTH-8){1'b0}}, byte_sel};
      F3_LH: begin
        data_o     = {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
        misalign_o = addr_lo_i[0];
      end
      F3_LHU: begin
        data_o     = {{(DATA_WIDTH-16){1'b0}}, half_sel};
        misalign_o = addr_lo_i[0];
      end
      default: begin
        data_o     = rdata_i;
        misalign_o = |addr_lo_i;
      end
    endcase
  end

endmodule

// File: rtl/wb_unit.sv
// Writeback stage: LSU-priority arbiter, registered RF write port, pending scoreboard.
// One-cycle latency from accept to rf_wen; stall is combinational from the scoreboard.
module wb_unit
  import wb_unit_pkg::*;
#(
  parameter int DATA_WIDTH  = WB_DATA_WIDTH,
  parameter int REG_NUM     = WB_REG_NUM,
  parameter int REG_NUM_BIT = WB_REG_NUM_BIT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   alu_valid,
  output logic                   alu_ready,
  input  logic [REG_NUM_BIT-1:0] alu_rd,
  input  logic [DATA_WIDTH-1:0]  alu_data,
  input  logic                   lsu_valid,
  output logic                   lsu_ready,
  input  logic [REG_NUM_BIT-1:0] lsu_rd,
  input  logic [DATA_WIDTH-1:0]  lsu_rdata,
  input  logic [2:0]             lsu_funct3,
  input  logic [1:0]             lsu_addr_lo,
  input  logic                   issue_valid,
  input  logic                   issue_wr,
  input  logic [REG_NUM_BIT-1:0] issue_rd,
  input  logic [REG_NUM_BIT-1:0] issue_rs1,
  input  logic [REG_NUM_BIT-1:0] issue_rs2,
  output logic                   stall,
  output logic                   rf_wen,
  output logic [REG_NUM_BIT-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0]  rf_wdata,
  output logic                   misalign
);

  wb_src_e                src;
  logic [DATA_WIDTH-1:0]  ld_data;
  logic                   ld_misalign;
  logic                   acc_vld;
  logic [REG_NUM_BIT-1:0] acc_rd;
  logic [DATA_WIDTH-1:0]  acc_data;
  logic                   acc_mis;

  logic                   wen_q, wen_d;
  logic [REG_NUM_BIT-1:0] waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
  logic                   mis_q, mis_d;
  logic                   clr_vld_q, clr_vld_d;
  logic [REG_NUM-1:0]     pend_q, pend_d;
  logic [REG_NUM-1:0]     clr_vec, set_vec;
  logic                   set_en;

  wb_unit_load_align #(.DATA_WIDTH(DATA_WIDTH)) u_load_align (
    .rdata_i    (lsu_rdata),
    .funct3_i   (lsu_funct3),
    .addr_lo_i  (lsu_addr_lo),
    .data_o     (ld_data),
    .misalign_o (ld_misalign)
  );

  // Ready is held low during reset so nothing is consumed that would be discarded.
  assign lsu_ready = rst_n;
  assign alu_ready = rst_n & ~lsu_valid;

  always_comb begin
    src = SRC_NONE;
    if (lsu_valid && lsu_ready) begin
      src = SRC_LSU;
    end else if (alu_valid && alu_ready) begin
      src = SRC_ALU;
    end
  end

  always_comb begin
    acc_vld  = 1'b0;
    acc_rd   = alu_rd;
    acc_data = alu_data;
    acc_mis  = 1'b0;
    case (src)
      SRC_ALU: begin
        acc_vld  = 1'b1;
        acc_rd   = alu_rd;
        acc_data = alu_data;
      end
      SRC_LSU: begin
        acc_vld  = 1'b1;
        acc_rd   = lsu_rd;
        acc_data = ld_data;
        acc_mis  = ld_misalign;
      end
      default: ;
    endcase
  end

  always_comb begin
    wen_d     = acc_vld && (acc_rd != '0) && !acc_mis;
    waddr_d   = acc_vld ? acc_rd : waddr_q;
    wdata_d   = acc_vld ? acc_data : wdata_q;
    mis_d     = acc_mis;
    clr_vld_d = acc_vld;
  end

  assign stall = issue_valid &&
                 (((issue_rs1 != '0) && pend_q[issue_rs1]) ||
                  ((issue_rs2 != '0) && pend_q[issue_rs2]) ||
                  (issue_wr && (issue_rd != '0) && pend_q[issue_rd]));

  assign set_en = issue_valid && issue_wr && !stall && (issue_rd != '0);

  // Clear targets the register being presented to the RF this cycle, write or misalign.
  always_comb begin
    clr_vec = '0;
    set_vec = '0;
    if (clr_vld_q) clr_vec[waddr_q] = 1'b1;
    if (set_en)    set_vec[issue_rd] = 1'b1;
    pend_d    = (pend_q & ~clr_vec) | set_vec;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wen_q     <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      mis_q     <= 1'b0;
      clr_vld_q <= 1'b0;
      pend_q    <= '0;
    end else begin
      wen_q     <= wen_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      mis_q     <= mis_d;
      clr_vld_q <= clr_vld_d;
      pend_q    <= pend_d;
    end
  end

  assign rf_wen   = wen_q;
  assign rf_waddr = waddr_q;
  assign rf_wdata = wdata_q;
  assign misalign = mis_q;

endmodule

// File: tb/tb_wb_unit.sv
// Directed bench for wb_unit: arbitration, load extension, misalignment, scoreboard, reset.
module tb_wb_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid, alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        lsu_valid, lsu_ready;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_rdata;
  logic [2:0]  lsu_funct3;
  logic [1:0]  lsu_addr_lo;
  logic        issue_valid, issue_wr;
  logic [4:0]  issue_rd, issue_rs1, issue_rs2;
  logic        stall, rf_wen, misalign;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_unit dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_rdata(lsu_rdata),
    .lsu_funct3(lsu_funct3), .lsu_addr_lo(lsu_addr_lo),
    .issue_valid(issue_valid), .issue_wr(issue_wr), .issue_rd(issue_rd),
    .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .stall(stall), .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .misalign(misalign)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [4:0] rd, input logic [2:0] f3,
                      input logic [1:0] lo, input logic [31:0] rdata);
    lsu_valid = 1'b1; lsu_rd = rd; lsu_funct3 = f3; lsu_addr_lo = lo; lsu_rdata = rdata;
    cyc();
    lsu_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    lsu_valid = 0; lsu_rd = 0; lsu_rdata = 0; lsu_funct3 = 0; lsu_addr_lo = 0;
    issue_valid = 0; issue_wr = 0; issue_rd = 0; issue_rs1 = 0; issue_rs2 = 0;
    #2;
    chk("rst_wen", rf_wen, 0);
    chk("rst_waddr", rf_waddr, 0);
    chk("rst_wdata", rf_wdata, 0);
    chk("rst_misalign", misalign, 0);
    chk("rst_alu_ready", alu_ready, 0);
    chk("rst_lsu_ready", lsu_ready, 0);
    cyc(); cyc();
    rst_n = 1'b1;
    #1;
    chk("lsu_ready_out_of_reset", lsu_ready, 1);

    // ALU write x5
    alu_valid = 1; alu_rd = 5; alu_data = 32'h1234;
    #1;
    chk("alu_ready_alone", alu_ready, 1);
    cyc();
    alu_valid = 0;
    chk("t1_wen", rf_wen, 1);
    chk("t1_waddr", rf_waddr, 5);
    chk("t1_wdata", rf_wdata, 32'h1234);
    cyc();
    chk("t1_idle", rf_wen, 0);

    // LSU and ALU together: LSU first, ALU next cycle
    lsu_valid = 1; lsu_rd = 3; lsu_funct3 = 3'b010; lsu_addr_lo = 0; lsu_rdata = 32'hCAFE_BABE;
    alu_valid = 1; alu_rd = 4; alu_data = 32'h55;
    #1;
    chk("t2_lsu_ready", lsu_ready, 1);
    chk("t2_alu_ready", alu_ready, 0);
    cyc();
    lsu_valid = 0;
    chk("t2_lsu_wen", rf_wen, 1);
    chk("t2_lsu_waddr", rf_waddr, 3);
    chk("t2_lsu_wdata", rf_wdata, 32'hCAFE_BABE);
    #1;
    chk("t2_alu_ready_after", alu_ready, 1);
    cyc();
    alu_valid = 0;
    chk("t2_alu_wen", rf_wen, 1);
    chk("t2_alu_waddr", rf_waddr, 4);
    chk("t2_alu_wdata", rf_wdata, 32'h55);
    cyc();
    chk("t2_idle", rf_wen, 0);

    // Load extension
    load(8, 3'b000, 2'd3, 32'h80FF_FFFF);
    chk("lb_wen", rf_wen, 1);
    chk("lb_data", rf_wdata, 32'hFFFF_FF80);
    load(8, 3'b100, 2'd3, 32'h80FF_FFFF);
    chk("lbu_data", rf_wdata, 32'h0000_0080);
    load(8, 3'b101, 2'd2, 32'hBEEF_0000);
    chk("lhu_data", rf_wdata, 32'h0000_BEEF);
    load(8, 3'b001, 2'd2, 32'h8001_0000);
    chk("lh_data", rf_wdata, 32'hFFFF_8001);
    load(8, 3'b000, 2'd1, 32'h0000_7F00);
    chk("lb_pos_data", rf_wdata, 32'h0000_007F);
    load(8, 3'b111, 2'd0, 32'hA5A5_5A5A);
    chk("undef_as_lw", rf_wdata, 32'hA5A5_5A5A);
    chk("undef_misalign", misalign, 0);

    // rd==0 accepted without write
    alu_valid = 1; alu_rd = 0; alu_data = 32'hDEAD;
    cyc();
    alu_valid = 0;
    chk("x0_wen", rf_wen, 0);

    // Misaligned LW to a pending register
    issue_valid = 1; issue_wr = 1; issue_rd = 9; issue_rs1 = 0; issue_rs2 = 0;
    #1;
    chk("t4_issue_nostall", stall, 0);
    cyc();
    issue_wr = 0; issue_rs1 = 9;
    #1;
    chk("t4_raw_stall", stall, 1);
    load(9, 3'b010, 2'd2, 32'h1111_2222);
    chk("t4_misalign", misalign, 1);
    chk("t4_wen", rf_wen, 0);
    chk("t4_stall_still", stall, 1);
    load(9, 3'b001, 2'd1, 32'h0);
    chk("t4_lh_misalign", misalign, 1);
    chk("t4_stall_cleared", stall, 0);
    cyc();
    chk("t4_misalign_pulse", misalign, 0);

    // RAW/WAW on x7, released after writeback
    issue_wr = 1; issue_rd = 7; issue_rs1 = 0; issue_rs2 = 0;
    cyc();
    issue_wr = 0; issue_rs1 = 7;
    #1;
    chk("t5_raw_stall", stall, 1);
    issue_rs1 = 0; issue_rs2 = 0;
    #1;
    chk("t5_rs0_nostall", stall, 0);
    issue_wr = 1; issue_rd = 7;
    #1;
    chk("t5_waw_stall", stall, 1);
    issue_wr = 0; issue_rs2 = 7;
    alu_valid = 1; alu_rd = 7; alu_data = 32'h77;
    #1;
    chk("t5_stall_acc", stall, 1);
    cyc();
    alu_valid = 0;
    chk("t5_wen", rf_wen, 1);
    chk("t5_waddr", rf_waddr, 7);
    chk("t5_stall_wen_cycle", stall, 1);
    cyc();
    chk("t5_stall_released", stall, 0);

    // Reset mid-operation
    issue_wr = 1; issue_rd = 10; issue_rs1 = 0; issue_rs2 = 0;
    cyc();
    issue_valid = 0; issue_wr = 0;
    alu_valid = 1; alu_rd = 11; alu_data = 32'hAA;
    cyc();
    alu_valid = 0;
    chk("t6_wen_before", rf_wen, 1);
    rst_n = 0;
    #1;
    chk("t6_rst_wen", rf_wen, 0);
    chk("t6_rst_wdata", rf_wdata, 0);
    chk("t6_rst_alu_ready", alu_ready, 0);
    cyc();
    rst_n = 1;
    issue_valid = 1; issue_rs1 = 10;
    #1;
    chk("t6_pending_cleared", stall, 0);
    issue_valid = 0;
    cyc();
    chk("t6_no_write", rf_wen, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
